// File: rtl/stream_demux.sv
// Single-entry stream demultiplexer: routes each accepted word to channel in_sel with one cycle of latency.
// Optional per-channel saturating transfer counters on port cnt when STREAM_DEMUX_STATS_EN is defined.
module stream_demux #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_data,
  input  logic [SELW-1:0]      in_sel,
  output logic [N-1:0]         out_valid,
  input  logic [N-1:0]         out_ready,
  output logic [N*WIDTH-1:0]   out_data,
`ifdef STREAM_DEMUX_STATS_EN
  output logic [N*8-1:0]       cnt,
`endif
  output logic                 err
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  // One extra bit so N == 2**SELW is representable in the range compare.
  localparam logic [SELW:0] NUM_CH = (SELW+1)'(N);

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [SELW-1:0]   sel_q, sel_d;
  logic              err_q, err_d;
  logic [N-1:0]      sel_oh;
  logic              drain, accept, in_range;

  always_comb begin
    sel_oh = '0;
    for (int k = 0; k < N; k++) begin
      sel_oh[k] = (sel_q == SELW'(k));
    end
  end

  assign drain    = (state_q == FULL) && |(out_ready & sel_oh);
  assign in_ready = !rst && ((state_q == EMPTY) || drain);
  assign accept   = in_valid && in_ready;
  assign in_range = ({1'b0, in_sel} < NUM_CH);

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    sel_d   = sel_q;
    err_d   = accept && !in_range;
    if (accept && in_range) begin
      state_d = FULL;
      data_d  = in_data;
      sel_d   = in_sel;
    end else if (drain) begin
      // Also covers an out-of-range accept while draining: the slot empties.
      state_d = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
      data_q  <= '0;
      sel_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    out_valid = '0;
    out_data  = '0;
    for (int k = 0; k < N; k++) begin
      if ((state_q == FULL) && sel_oh[k]) begin
        out_valid[k]                 = 1'b1;
        out_data[k*WIDTH +: WIDTH]   = data_q;
      end
    end
  end

  assign err = err_q;

`ifdef STREAM_DEMUX_STATS_EN
  logic [N*8-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int k = 0; k < N; k++) begin
      if (drain && sel_oh[k] && (cnt_q[k*8 +: 8] != 8'hFF)) begin
        cnt_d[k*8 +: 8] = cnt_q[k*8 +: 8] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;
`endif

endmodule
